// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner. A divider sets the slot
// length, the digit index steps once per slot, and the displayed data is
// held in a shadow register that only changes at a frame wrap.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 100000,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] val;
    logic [NUM_DIGITS-1:0]   dpm;
    logic [NUM_DIGITS-1:0]   blk;
  } disp_t;

  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic          tick, wrap;
  disp_t         shadow, pend_buf, in_req;
  logic          pend;

  assign tick   = (div == DW'(CLK_DIV - 1));
  assign wrap   = tick && (idx == IW'(NUM_DIGITS - 1));
  assign in_req = '{val: value, dpm: dp_in, blk: blank_in};

  // Slot divider and digit index; the index wraps after the last digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (tick) begin
      div <= '0;
      idx <= wrap ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Double-buffered capture: loads park in pend_buf until the wrap, except a
  // load landing on the wrap edge itself, which goes straight to the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow   <= '0;
      pend_buf <= '0;
      pend     <= 1'b0;
    end else if (wrap) begin
      if (load)      shadow <= in_req;
      else if (pend) shadow <= pend_buf;
      pend <= 1'b0;
    end else if (load) begin
      pend_buf <= in_req;
      pend     <= 1'b1;
    end
  end

  // Hex nibble to active-high {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h7E; 4'h1: hex_seg = 7'h30;
      4'h2: hex_seg = 7'h6D; 4'h3: hex_seg = 7'h79;
      4'h4: hex_seg = 7'h33; 4'h5: hex_seg = 7'h5B;
      4'h6: hex_seg = 7'h5F; 4'h7: hex_seg = 7'h70;
      4'h8: hex_seg = 7'h7F; 4'h9: hex_seg = 7'h7B;
      4'hA: hex_seg = 7'h77; 4'hB: hex_seg = 7'h1F;
      4'hC: hex_seg = 7'h4E; 4'hD: hex_seg = 7'h3D;
      4'hE: hex_seg = 7'h4F; default: hex_seg = 7'h47;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0] zero_from;
  logic [3:0]            nib;
  logic                  force_blank, lz_blank, all_zero;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  // Decode of the current digit. Leading-zero blanking darkens the segments
  // only; the decimal point survives it so "0." style readouts still work.
  // A forced blank darkens the decimal point as well.
  always_comb begin
    all_zero = 1'b1;
    zero_from = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (shadow.val[k*4 +: 4] == 4'h0);
      zero_from[k] = all_zero;
    end
    nib         = shadow.val[idx*4 +: 4];
    force_blank = shadow.blk[idx];
    lz_blank    = (LZ_SUPPRESS != 0) && (idx != '0) && zero_from[idx];
    an_nxt      = '1;
    an_nxt[idx] = 1'b0;
    seg_nxt     = (force_blank || lz_blank) ? 7'h7F : ~hex_seg(nib);
    dp_nxt      = force_blank ? 1'b1 : ~shadow.dpm[idx];
  end

  // Registered outputs with a one-clock all-off gap at every slot boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= an_nxt;
        seg <= seg_nxt;
        dp  <= dp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: two scanners (leading-zero blanking on/off) share all
// inputs; expected per-digit outputs are queued when stimulus is applied and
// popped as each digit slot is observed.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0, blank_in = '0;
  logic        load = 1'b0;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fd_a, fd_b;

  int tests = 0;
  int failed = 0;

  typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .LZ_SUPPRESS(1)) dut_a (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .an(an_a), .seg(seg_a), .dp(dp_a),
    .frame_done(fd_a));

  seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .LZ_SUPPRESS(0)) dut_b (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .an(an_b), .seg(seg_b), .dp(dp_b),
    .frame_done(fd_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // segs = {seg3,seg2,seg1,seg0}, dpn = active-low dp per digit.
  task automatic push_frame(input bit to_b, input logic [27:0] segs, input logic [3:0] dpn);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.an  = ~(4'b0001 << k);
      e.seg = segs[k*7 +: 7];
      e.dp  = dpn[k];
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  // Entered on the negedge just after a wrap edge (or reset release).
  task automatic check_frame(input string tag);
    exp_t ea, eb;
    bit   use_b;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ea = qa.pop_front();
      use_b = (qb.size() > 0);
      if (use_b) eb = qb.pop_front();
      chk($sformatf("%s d%0d an", tag, k), 32'(an_a), 32'(ea.an));
      chk($sformatf("%s d%0d seg", tag, k), 32'(seg_a), 32'(ea.seg));
      chk($sformatf("%s d%0d dp", tag, k), 32'(dp_a), 32'(ea.dp));
      chk($sformatf("%s d%0d fd", tag, k), 32'(fd_a), 32'(0));
      if (use_b) begin
        chk($sformatf("%s B d%0d an", tag, k), 32'(an_b), 32'(eb.an));
        chk($sformatf("%s B d%0d seg", tag, k), 32'(seg_b), 32'(eb.seg));
        chk($sformatf("%s B d%0d dp", tag, k), 32'(dp_b), 32'(eb.dp));
      end
      repeat (2) @(negedge clk);
      chk($sformatf("%s d%0d an3", tag, k), 32'(an_a), 32'(ea.an));
      @(negedge clk);
      chk($sformatf("%s d%0d gap", tag, k), 32'(an_a), 32'hF);
      chk($sformatf("%s d%0d gapseg", tag, k), 32'(seg_a), 32'h7F);
      chk($sformatf("%s d%0d fd_end", tag, k), 32'(fd_a), 32'(k == 3));
    end
  endtask

  initial begin
    // Reset state, held across clock edges.
    repeat (3) @(negedge clk);
    chk("rst an", 32'(an_a), 32'hF);
    chk("rst seg", 32'(seg_a), 32'h7F);
    chk("rst dp", 32'(dp_a), 32'h1);
    chk("rst fd", 32'(fd_a), 32'h0);
    reset = 1'b0;

    // Zero shadow: digit0 shows 0, upper digits leading-zero blanked.
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF);
    push_frame(1, {7'h01, 7'h01, 7'h01, 7'h01}, 4'hF);
    check_frame("zero1");
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF);
    check_frame("zero2");

    // Mid-frame load waits for the wrap.
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF);
    fork
      check_frame("pre12A0");
      begin
        repeat (5) @(negedge clk);
        value = 16'h12A0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    join

    // 12A0 displayed; two loads inside this frame, newest wins.
    push_frame(0, {7'h4F, 7'h12, 7'h08, 7'h01}, 4'hF);
    fork
      check_frame("12A0");
      begin
        repeat (2) @(negedge clk);
        value = 16'h1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        value = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    join

    // 2222 displayed; 4444 pends, then 3333 loads on the wrap edge.
    push_frame(0, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF);
    fork
      check_frame("2222");
      begin
        repeat (3) @(negedge clk);
        value = 16'h4444; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (11) @(negedge clk);
        value = 16'h3333; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    join
    push_frame(0, {7'h06, 7'h06, 7'h06, 7'h06}, 4'hF);
    check_frame("3333a");

    // 3333 stays: the wrap-edge load also cleared the 4444 pending.
    push_frame(0, {7'h06, 7'h06, 7'h06, 7'h06}, 4'hF);
    fork
      check_frame("3333b");
      begin
        repeat (6) @(negedge clk);
        value = 16'h0005; dp_in = 4'b0010; blank_in = 4'b0001; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    join

    // Forced blank on digit0, dp on digit1, LZ on vs off.
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1101);
    push_frame(1, {7'h01, 7'h01, 7'h01, 7'h7F}, 4'b1101);
    check_frame("dpblank");

    // Load pending in the idx=2 slot, then reset discards it.
    repeat (9) @(negedge clk);
    value = 16'h9999; dp_in = '0; blank_in = '0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst an", 32'(an_a), 32'hF);
    chk("midrst seg", 32'(seg_a), 32'h7F);
    chk("midrst dp", 32'(dp_a), 32'h1);
    chk("midrst fd", 32'(fd_a), 32'h0);
    @(negedge clk);
    chk("midrst hold an", 32'(an_a), 32'hF);
    reset = 1'b0;
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF);
    push_frame(1, {7'h01, 7'h01, 7'h01, 7'h01}, 4'hF);
    check_frame("postrst1");
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF);
    check_frame("postrst2");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
